// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit-trace buffer: the ebreak encoding, the
// field widths of a trace record and the control states.
package commit_trace_pkg;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  localparam int PC_W   = 64;
  localparam int INSN_W = 32;
  localparam int RD_W   = 5;
  localparam int DAT_W  = 64;
  localparam int SEQ_W  = 64;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
    logic [RD_W-1:0]   rd;
    logic              rf_we;
    logic [DAT_W-1:0]  rd_dat;
    logic [SEQ_W-1:0]  seq;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/commit_trace_if.sv
// Bundle of the write-back debug port, the harness handshake and the status
// outputs of the commit-trace buffer.
interface commit_trace_if #(parameter int AW = 3);
  import commit_trace_pkg::*;

  logic              i_valid;
  logic [PC_W-1:0]   i_pc;
  logic [INSN_W-1:0] i_insn;
  logic [RD_W-1:0]   i_rd;
  logic              i_rf_we;
  logic [DAT_W-1:0]  i_rd_dat;
  logic              i_ready;

  logic              o_valid;
  logic [PC_W-1:0]   o_pc;
  logic [INSN_W-1:0] o_insn;
  logic [RD_W-1:0]   o_rd;
  logic              o_rf_we;
  logic [DAT_W-1:0]  o_rd_dat;
  logic [SEQ_W-1:0]  o_seq;
  logic [AW:0]       o_count;
  logic              o_overflow;
  logic [63:0]       o_cycle_cnt;
  logic [63:0]       o_instr_cnt;
  logic              o_trap;
  logic [PC_W-1:0]   o_trap_pc;
  logic              o_done;

  modport master (
    output i_valid, i_pc, i_insn, i_rd, i_rf_we, i_rd_dat, i_ready,
    input  o_valid, o_pc, o_insn, o_rd, o_rf_we, o_rd_dat, o_seq, o_count,
           o_overflow, o_cycle_cnt, o_instr_cnt, o_trap, o_trap_pc, o_done
  );

  modport slave (
    input  i_valid, i_pc, i_insn, i_rd, i_rf_we, i_rd_dat, i_ready,
    output o_valid, o_pc, o_insn, o_rd, o_rf_we, o_rd_dat, o_seq, o_count,
           o_overflow, o_cycle_cnt, o_instr_cnt, o_trap, o_trap_pc, o_done
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with AW+1 bit wrapping pointers;
// a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [AW:0]  count_o
);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // NOTE: sequential state is always assigned with <=, so every always_ff
  // reads the pre-edge value of every register regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // the pointers say they were written, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/commit_trace.sv
// Commit-trace buffer: packs retired instructions into sequence-tagged records,
// runs the RUN/DRAIN/DONE control and keeps cycle/instruction counters.
module commit_trace
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic           clk,
  input logic           rst,
  commit_trace_if.slave bus
);

  state_e            state_q;
  logic              overflow_q, trap_q, done_q;
  logic [63:0]       cycle_q, instr_q;
  logic [PC_W-1:0]   trap_pc_q;

  trace_rec_t        rec_in, rec_out;
  logic              push, pop, empty, full;
  logic [AW:0]       count;

  assign push = bus.i_valid && (state_q == ST_RUN);
  assign pop  = !empty && bus.i_ready;

  // Writes to x0 never reach the register file, so they are reported as such.
  assign rec_in = '{
    pc:     bus.i_pc,
    insn:   bus.i_insn,
    rd:     bus.i_rd,
    rf_we:  bus.i_rf_we && (bus.i_rd != '0),
    rd_dat: bus.i_rd_dat,
    seq:    instr_q
  };

  trace_fifo #(.DEPTH(DEPTH), .AW(AW), .W(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (bus.i_ready),
    .data_i  (rec_in),
    .data_o  (rec_out),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
      trap_q     <= 1'b0;
      done_q     <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
      trap_pc_q  <= '0;
    end else begin
      if (push && full && !pop) overflow_q <= 1'b1;
      case (state_q)
        ST_RUN: begin
          cycle_q <= cycle_q + 64'd1;
          if (push) begin
            instr_q <= instr_q + 64'd1;
            if (bus.i_insn == EBREAK_INSN) begin
              trap_q    <= 1'b1;
              trap_pc_q <= bus.i_pc;
              state_q   <= ST_DRAIN;
            end
          end
        end
        // Uses the registered empty flag, so DONE lands one cycle after the last pop.
        ST_DRAIN: begin
          if (empty) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign bus.o_valid     = !empty;
  assign bus.o_pc        = rec_out.pc;
  assign bus.o_insn      = rec_out.insn;
  assign bus.o_rd        = rec_out.rd;
  assign bus.o_rf_we     = rec_out.rf_we;
  assign bus.o_rd_dat    = rec_out.rd_dat;
  assign bus.o_seq       = rec_out.seq;
  assign bus.o_count     = count;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_cycle_cnt = cycle_q;
  assign bus.o_instr_cnt = instr_q;
  assign bus.o_trap      = trap_q;
  assign bus.o_trap_pc   = trap_pc_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_commit_trace.sv
// Bench for commit_trace: a queue-based reference model checked on every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_commit_trace;
  import commit_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  commit_trace_if #(.AW(AW)) bus ();
  commit_trace #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records and the phase of the trace session.
  trace_rec_t  mq[$];
  int          phase_m;            // 0 = running, 1 = draining, 2 = finished
  logic        ovf_m, trap_m;
  logic [63:0] cyc_m, ins_m, tpc_m;
  bit          pop_m, full_m, empty_m;
  trace_rec_t  r_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      phase_m = 0; ovf_m = 0; trap_m = 0;
      cyc_m = 0; ins_m = 0; tpc_m = 0;
    end else begin
      empty_m = (mq.size() == 0);
      full_m  = (mq.size() == DEPTH);
      pop_m   = !empty_m && bus.i_ready;
      if (pop_m) void'(mq.pop_front());
      if (phase_m == 0) begin
        cyc_m = cyc_m + 1;
        if (bus.i_valid) begin
          r_m.pc = bus.i_pc; r_m.insn = bus.i_insn; r_m.rd = bus.i_rd;
          r_m.rf_we = bus.i_rf_we && (bus.i_rd != 0);
          r_m.rd_dat = bus.i_rd_dat; r_m.seq = ins_m;
          if (full_m && !pop_m) ovf_m = 1;
          else mq.push_back(r_m);
          ins_m = ins_m + 1;
          if (bus.i_insn == EBREAK_INSN) begin
            trap_m = 1; tpc_m = bus.i_pc; phase_m = 1;
          end
        end
      end else if (phase_m == 1 && empty_m) begin
        phase_m = 2;
      end
    end
  end

  always @(negedge clk) begin
    check("valid", {63'd0, bus.o_valid}, {63'd0, mq.size() != 0});
    check("count", {60'd0, bus.o_count}, 64'(mq.size()));
    check("overflow", {63'd0, bus.o_overflow}, {63'd0, ovf_m});
    check("cycle_cnt", bus.o_cycle_cnt, cyc_m);
    check("instr_cnt", bus.o_instr_cnt, ins_m);
    check("trap", {63'd0, bus.o_trap}, {63'd0, trap_m});
    check("trap_pc", bus.o_trap_pc, tpc_m);
    check("done", {63'd0, bus.o_done}, {63'd0, phase_m == 2});
    if (mq.size() != 0) begin
      check("head_pc", bus.o_pc, mq[0].pc);
      check("head_insn", {32'd0, bus.o_insn}, {32'd0, mq[0].insn});
      check("head_rd", {59'd0, bus.o_rd}, {59'd0, mq[0].rd});
      check("head_rf_we", {63'd0, bus.o_rf_we}, {63'd0, mq[0].rf_we});
      check("head_dat", bus.o_rd_dat, mq[0].rd_dat);
      check("head_seq", bus.o_seq, mq[0].seq);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] insn,
                        input logic [4:0] rd, input logic we, input logic [63:0] dat);
    bus.i_valid = 1'b1; bus.i_pc = pc; bus.i_insn = insn;
    bus.i_rd = rd; bus.i_rf_we = we; bus.i_rd_dat = dat;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle();
    bus.i_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      commit(64'h8000_0100 + 64'(i * 4), 32'h0000_0013 + 32'(i << 7),
             5'(i + 1), 1'b1, 64'hA000 + 64'(i));
  endtask

  bit seen_empty;

  initial begin
    bus.i_valid = 0; bus.i_pc = 0; bus.i_insn = 0; bus.i_rd = 0;
    bus.i_rf_we = 0; bus.i_rd_dat = 0; bus.i_ready = 0;
    step(); step();
    #1 rst = 1'b0;
    step();
    check("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("rst_count", {60'd0, bus.o_count}, 64'd0);
    check("rst_instr", bus.o_instr_cnt, 64'd0);

    // Single commit, then a simultaneous pop plus x0 write.
    commit(64'h8000_0000, 32'h0010_0093, 5'd1, 1'b1, 64'd1);
    check("single_valid", {63'd0, bus.o_valid}, 64'd1);
    check("single_seq", bus.o_seq, 64'd0);
    check("single_count", {60'd0, bus.o_count}, 64'd1);
    check("single_instr", bus.o_instr_cnt, 64'd1);
    bus.i_ready = 1'b1;
    commit(64'h8000_0004, 32'h0050_0013, 5'd0, 1'b1, 64'd5);
    check("x0_rd", {59'd0, bus.o_rd}, 64'd0);
    check("x0_rf_we", {63'd0, bus.o_rf_we}, 64'd0);
    check("x0_seq", bus.o_seq, 64'd1);
    check("x0_count", {60'd0, bus.o_count}, 64'd1);
    step();
    check("x0_drained", {60'd0, bus.o_count}, 64'd0);

    // Overflow: nine commits into eight slots, then drain in order.
    do_reset();
    fill(9);
    check("ovf_count", {60'd0, bus.o_count}, 64'd8);
    check("ovf_flag", {63'd0, bus.o_overflow}, 64'd1);
    check("ovf_instr", bus.o_instr_cnt, 64'd9);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_seq", bus.o_seq, 64'(i));
      step();
    end
    check("ovf_empty", {63'd0, bus.o_valid}, 64'd0);
    check("ovf_sticky", {63'd0, bus.o_overflow}, 64'd1);

    // Full FIFO with a simultaneous pop accepts the push.
    do_reset();
    fill(8);
    bus.i_ready = 1'b1;
    commit(64'h8000_0200, 32'h0000_0013, 5'd9, 1'b1, 64'hBEEF);
    bus.i_ready = 1'b0;
    check("fullpop_count", {60'd0, bus.o_count}, 64'd8);
    check("fullpop_ovf", {63'd0, bus.o_overflow}, 64'd0);
    check("fullpop_head", bus.o_seq, 64'd1);
    check("fullpop_instr", bus.o_instr_cnt, 64'd9);

    // Trap and drain.
    do_reset();
    fill(3);
    commit(64'h8000_0010, EBREAK_INSN, 5'd0, 1'b0, 64'd0);
    fill(2);
    check("trap_flag", {63'd0, bus.o_trap}, 64'd1);
    check("trap_pc", bus.o_trap_pc, 64'h8000_0010);
    check("trap_count", {60'd0, bus.o_count}, 64'd4);
    check("trap_instr", bus.o_instr_cnt, 64'd4);
    bus.i_ready = 1'b1;
    seen_empty = 0;
    for (int i = 0; i < 20 && !seen_empty; i++) begin
      step();
      if (bus.o_count == 0) begin
        seen_empty = 1;
        check("done_not_early", {63'd0, bus.o_done}, 64'd0);
        step();
        check("done_after_pop", {63'd0, bus.o_done}, 64'd1);
      end
    end
    check("drain_in_time", {63'd0, seen_empty}, 64'd1);
    step(); step();
    check("done_sticky", {63'd0, bus.o_done}, 64'd1);

    // Asynchronous reset between clock edges while records are queued.
    do_reset();
    fill(3);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("arst_count", {60'd0, bus.o_count}, 64'd0);
    check("arst_instr", bus.o_instr_cnt, 64'd0);
    check("arst_cycle", bus.o_cycle_cnt, 64'd0);
    #1 rst = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace.md
# commit_trace

Commit-trace buffer that sits directly downstream of the CPU core's write-back stage. It captures every retired instruction from the write-back debug port into a small FIFO for the difftest harness, tagging each record with a sequence number. It also keeps cycle and retired-instruction counters, detects the `ebreak` halt convention and reports when the trace has fully drained.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `AW`, 3, log2(`DEPTH`)
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `i_valid` in 1 — write-back stage holds a retiring instruction this cycle
- `i_pc` in 64 — PC of the retiring instruction
- `i_insn` in 32 — instruction word
- `i_rd` in 5 — destination register
- `i_rf_we` in 1 — register-file write enable
- `i_rd_dat` in 64 — write-back data
- `i_ready` in 1 — harness accepts the head record
- `o_valid` out 1 — head record present (FIFO not empty)
- `o_pc`, `o_insn`, `o_rd`, `o_rf_we`, `o_rd_dat` out 64/32/5/1/64 — head record fields
- `o_seq` out 64 — retire sequence number of the head record
- `o_count` out AW+1 — current FIFO occupancy
- `o_overflow` out 1 — sticky: a commit was dropped because the FIFO was full
- `o_cycle_cnt` out 64 — cycles spent in RUN
- `o_instr_cnt` out 64 — instructions retired in RUN
- `o_trap` out 1 — sticky: `ebreak` has retired
- `o_trap_pc` out 64 — PC of that `ebreak`
- `o_done` out 1 — trap seen and trace fully drained

## Operation
- **Reset values:**
  - State is RUN.
  - Both pointers and `o_count` are 0.
  - `o_valid`, `o_overflow`, `o_trap` and `o_done` are 0.
  - All counters and `o_trap_pc` are 0.
  - Head data fields are don't-care while `o_valid`=0.
- **Capture (push):**
  - A push occurs when `i_valid` is 1 and state is RUN.
  - Record = {pc, insn, rd, rf_we & (rd≠0), rd_dat, seq = `o_instr_cnt` before increment}.
  - Writes to x0 are therefore always reported with `rf_we`=0.
- **Instruction counter:** `o_instr_cnt` increments on every push attempt in RUN, whether the record is stored or dropped. It wraps modulo 2^64.
- **Cycle counter:** `o_cycle_cnt` increments every cycle in RUN, including the trap cycle. It wraps modulo 2^64.
- **Pop:** occurs when `o_valid` is 1 and `i_ready` is 1. The read pointer advances.
- **Full-FIFO push:**
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted and occupancy is unchanged.
  - If the FIFO is full with no pop, the record is dropped and `o_overflow` is set. It stays set until reset.
- **Empty FIFO:** a simultaneous push and pop on an empty FIFO pops nothing, since `o_valid`=0. Only the push takes effect.
- **Pointers:** `AW`+1 bits wide; wrap naturally. Full when the MSBs differ and the low bits are equal.
- **State machine:**
  - **RUN:** on a push whose `i_insn` = 32'h0010_0073 (`ebreak`), the record is enqueued normally (or dropped if the FIFO is full). At the same time `o_trap` is set, `o_trap_pc` is set to `i_pc`, and the state goes to DRAIN.
  - **DRAIN:** `i_valid` is ignored (no push, no count). Go to DONE in the cycle after occupancy reaches 0.
  - **DONE:** `o_done`=1. Terminal until reset.
  - Reaching DONE from DRAIN uses the registered empty condition, so a FIFO already empty at trap time reaches DONE 2 cycles after the trap commit.
- **Reset mid-operation:** clears everything immediately (asynchronous). Records still in the FIFO are lost.

## Timing
- Write latency 1: a commit at edge N appears on `o_*` after edge N (first-word fall-through from the storage array). `o_valid` is registered.
- Throughput 1 record/cycle in and out.
- No combinational path from `i_ready` or `i_valid` to any output.
- `o_count`, `o_overflow`, `o_trap` and `o_done` are registered.

## Structure
- Shared defines file holds the `ebreak` encoding constant and the record field widths.
- One natural sub-module, `trace_fifo`: a parameterised synchronous FIFO with push/pop/full/empty/count.
- The state machine, counters and record packing live in the top.
- Storage is a plain register array with no reset on data.

## Test plan
- **Single commit:** reset, then `i_valid`=1, pc=0x8000_0000, insn=0x0010_0093, rd=1, rf_we=1, dat=1, with `i_ready`=0. Next cycle: `o_valid`=1, `o_seq`=0, `o_count`=1, `o_instr_cnt`=1.
- **x0 masking:** commit rd=0, rf_we=1. Head shows `o_rf_we`=0 and `o_rd`=0.
- **Overflow:** 9 back-to-back commits, `i_ready`=0, DEPTH=8.
  - `o_count`=8 and `o_overflow`=1; `o_instr_cnt`=9.
  - Draining yields seq 0..7 in order.
- **Full with simultaneous pop:** fill to 8, then push with `i_ready`=1. The push is accepted, `o_count` stays 8 and `o_overflow` stays 0.
- **Trap drain:**
  - 3 commits, then `ebreak` at pc 0x8000_0010, then 2 more `i_valid` cycles.
  - `o_trap`=1 and `o_trap_pc`=0x8000_0010.
  - Only 4 records are stored and `o_instr_cnt`=4.
  - With `i_ready`=1, `o_done` rises the cycle after the last pop, and `o_cycle_cnt` stops incrementing.
- **Async reset mid-drain:** assert `rst` between clock edges while the FIFO is non-empty. All outputs return to reset values at once, without waiting for a clock edge.
